// File: rtl/pooling_pkg.sv
// Shared definitions for the pooling / unpooling pair: default sizes,
// expansion mode encodings and the unpooling FSM state type.
package pooling_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_UP_LOG2    = 6;

    localparam logic MODE_MAX_REPLICATE = 1'b1;
    localparam logic MODE_AVG_INTERP    = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } unpool_state_t;

endpackage

// File: rtl/unpool_interp_dp.sv
// Interpolation datapath for unpooling: holds delta and the scaled accumulator
// and presents the next beat value for the top-level output register.
module unpool_interp_dp
    import pooling_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned UP_LOG2    = DEFAULT_UP_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic                  mode_q,
    input  logic [DATA_WIDTH-1:0] cur,
    input  logic [DATA_WIDTH-1:0] prev,
    output logic [DATA_WIDTH-1:0] beat_data
);

    localparam int unsigned AW = DATA_WIDTH + UP_LOG2 + 1;

    logic signed [DATA_WIDTH:0] delta_q;
    logic signed [DATA_WIDTH:0] delta_in;
    logic signed [DATA_WIDTH:0] delta_sel;
    logic signed [AW-1:0]       acc_q;
    logic signed [AW-1:0]       acc_base;
    logic signed [AW-1:0]       acc_next;

    // On load the first step is folded in, so beat k=1 is ready the cycle after acceptance.
    always_comb begin
        delta_in  = $signed({1'b0, cur}) - $signed({1'b0, prev});
        delta_sel = load ? delta_in : delta_q;
        acc_base  = load ? $signed({1'b0, prev, {UP_LOG2{1'b0}}}) : acc_q;
        acc_next  = acc_base + $signed({{UP_LOG2{delta_sel[DATA_WIDTH]}}, delta_sel});
    end

    // acc_next stays within [0, max<<UP_LOG2], so the slice equals acc_next >>> UP_LOG2.
    always_comb begin
        beat_data = acc_next[UP_LOG2 +: DATA_WIDTH];
        if (mode_q == MODE_MAX_REPLICATE) begin
            beat_data = cur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            delta_q <= '0;
            acc_q   <= '0;
        end else begin
            if (load) begin
                delta_q <= delta_in;
            end
            if (load || step) begin
                acc_q <= acc_next;
            end
        end
    end

endmodule

// File: rtl/unpooling.sv
// Unpooling: expands each pooled sample into 2**UP_LOG2 output beats, either
// replicated or linearly interpolated from the previous pooled value.
module unpooling
    import pooling_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned UP_LOG2    = DEFAULT_UP_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int unsigned FACTOR = 1 << UP_LOG2;
    localparam int unsigned KW     = UP_LOG2 + 1;
    localparam logic [KW-1:0] K_FIRST = KW'(1);
    localparam logic [KW-1:0] K_LAST  = KW'(FACTOR);

    unpool_state_t state_q, state_d;

    logic [KW-1:0]         k_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] cur_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DATA_WIDTH-1:0] cur_sel;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  mode_q;
    logic                  mode_sel;
    logic                  out_last_q;
    logic                  load;
    logic                  step;
    logic                  block_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        block_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (k_q == K_LAST) begin
                        block_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // During the accepting cycle the datapath must see the incoming sample and mode.
    always_comb begin
        cur_sel  = load ? in_data : cur_q;
        mode_sel = load ? mode : mode_q;
    end

    unpool_interp_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .UP_LOG2    (UP_LOG2)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .mode_q    (mode_sel),
        .cur       (cur_sel),
        .prev      (prev_q),
        .beat_data (beat_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q        <= '0;
            prev_q     <= '0;
            cur_q      <= '0;
            mode_q     <= MODE_AVG_INTERP;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            if (load) begin
                cur_q      <= in_data;
                mode_q     <= mode;
                k_q        <= K_FIRST;
                out_data_q <= beat_data;
                out_last_q <= (K_FIRST == K_LAST);
            end
            if (step) begin
                k_q        <= k_q + K_FIRST;
                out_data_q <= beat_data;
                out_last_q <= ((k_q + K_FIRST) == K_LAST);
            end
            if (block_done) begin
                prev_q     <= cur_q;
                out_last_q <= 1'b0;
            end
        end
    end

    assign out_data = out_data_q;
    assign out_last = out_last_q;

endmodule

// File: tb/tb_unpooling.sv
// Directed self-checking bench for unpooling: a UP_LOG2=2 instance for most
// scenarios and a default-parameter instance for the full 64-beat block.
module tb_unpooling;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst_a = 1'b1, in_valid_a = 1'b0, in_ready_a, mode_a = 1'b0;
    logic       out_valid_a, out_ready_a = 1'b1, out_last_a;
    logic [7:0] in_data_a = '0, out_data_a;

    logic       rst_b = 1'b1, in_valid_b = 1'b0, in_ready_b, mode_b = 1'b0;
    logic       out_valid_b, out_ready_b = 1'b1, out_last_b;
    logic [7:0] in_data_b = '0, out_data_b;

    logic [7:0] beats[$];
    logic       lasts[$];

    unpooling #(.DATA_WIDTH(8), .UP_LOG2(2)) u_dut_a (
        .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .mode(mode_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_data(out_data_a), .out_last(out_last_a)
    );

    unpooling #(.DATA_WIDTH(8), .UP_LOG2(6)) u_dut_b (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .mode(mode_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_data(out_data_b), .out_last(out_last_b)
    );

    task automatic reset_a();
        rst_a = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] d, input logic m);
        int g = 0;
        in_valid_a = 1'b1; in_data_a = d; mode_a = m;
        while (!in_ready_a && g < 100) begin
            @(posedge clk); #1; g++;
        end
        if (!in_ready_a) begin
            checks++; errors++;
            $display("FAIL send_a_timeout in_ready=%b required 1", in_ready_a);
        end
        @(posedge clk); #1;
        in_valid_a = 1'b0;
    endtask

    task automatic collect_a(input bit scramble);
        int g = 0;
        bit done = 0;
        beats.delete(); lasts.delete();
        out_ready_a = 1'b1;
        while (!done && g < 200) begin
            if (out_valid_a) begin
                beats.push_back(out_data_a);
                lasts.push_back(out_last_a);
                if (out_last_a) done = 1;
            end
            if (scramble) begin
                in_data_a = 8'($urandom);
                mode_a = ~mode_a;
            end
            @(posedge clk); #1; g++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL collect_a_timeout beats=%0d required out_last", beats.size());
        end
    endtask

    task automatic test_reset();
        reset_a();
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b0;
        checks++;
        if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid_a); end
        checks++;
        if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready_a); end
        checks++;
        if (out_data_a !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data_a); end
        checks++;
        if (out_last_a !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last_a); end
        checks++;
        if ({out_valid_b, in_ready_b, out_data_b} !== {1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL reset_b got v=%b r=%b d=%h want v=0 r=1 d=00", out_valid_b, in_ready_b, out_data_b);
        end
    endtask

    task automatic test_reset_mid_block();
        logic [7:0] exp [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
        reset_a();
        send_a(8'h80, 1'b0);
        @(posedge clk); #1;
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        checks++;
        if (out_valid_a !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid_a); end
        checks++;
        if (in_ready_a !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready_a); end
        send_a(8'h40, 1'b0);
        collect_a(1'b0);
        checks++;
        if (beats.size() != 4) begin errors++; $display("FAIL midrst_count got %0d want 4", beats.size()); end
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            checks++;
            if (beats[i] !== exp[i]) begin errors++; $display("FAIL midrst_beat%0d got %h want %h", i + 1, beats[i], exp[i]); end
        end
    endtask

    task automatic test_replicate();
        reset_a();
        send_a(8'h50, 1'b1);
        collect_a(1'b0);
        checks++;
        if (beats.size() != 4) begin errors++; $display("FAIL repl_count got %0d want 4", beats.size()); end
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            checks++;
            if (beats[i] !== 8'h50 || lasts[i] !== (i == 3)) begin
                errors++;
                $display("FAIL repl_beat%0d got %h/%b want 50/%b", i + 1, beats[i], lasts[i], (i == 3));
            end
        end
        checks++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL repl_idle got r=%b v=%b want r=1 v=0", in_ready_a, out_valid_a);
        end
    endtask

    task automatic test_interp();
        logic [7:0] up [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
        logic [7:0] dn [4] = '{8'h30, 8'h20, 8'h10, 8'h00};
        reset_a();
        send_a(8'h40, 1'b0);
        collect_a(1'b0);
        checks++;
        if (beats.size() != 4) begin errors++; $display("FAIL interp_up_count got %0d want 4", beats.size()); end
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            checks++;
            if (beats[i] !== up[i]) begin errors++; $display("FAIL interp_up_beat%0d got %h want %h", i + 1, beats[i], up[i]); end
        end
        send_a(8'h00, 1'b0);
        collect_a(1'b0);
        checks++;
        if (beats.size() != 4) begin errors++; $display("FAIL interp_dn_count got %0d want 4", beats.size()); end
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            checks++;
            if (beats[i] !== dn[i]) begin errors++; $display("FAIL interp_dn_beat%0d got %h want %h", i + 1, beats[i], dn[i]); end
        end
    endtask

    task automatic test_negative_floor();
        logic [7:0] exp [4] = '{8'h02, 8'h01, 8'h00, 8'h00};
        reset_a();
        send_a(8'h03, 1'b1);
        collect_a(1'b0);
        send_a(8'h00, 1'b0);
        collect_a(1'b0);
        checks++;
        if (beats.size() != 4) begin errors++; $display("FAIL negfloor_count got %0d want 4", beats.size()); end
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            checks++;
            if (beats[i] !== exp[i]) begin errors++; $display("FAIL negfloor_beat%0d got %h want %h", i + 1, beats[i], exp[i]); end
        end
    endtask

    task automatic test_default_factor();
        int g = 0;
        bit done = 0;
        beats.delete(); lasts.delete();
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b0;
        in_valid_b = 1'b1; in_data_b = 8'hFF; mode_b = 1'b0;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        while (!done && g < 300) begin
            if (out_valid_b) begin
                beats.push_back(out_data_b);
                lasts.push_back(out_last_b);
                if (out_last_b) done = 1;
            end
            @(posedge clk); #1; g++;
        end
        checks++;
        if (beats.size() != 64) begin errors++; $display("FAIL f64_count got %0d want 64", beats.size()); end
        if (beats.size() == 64) begin
            checks++;
            if (beats[0] !== 8'h03) begin errors++; $display("FAIL f64_beat1 got %h want 03", beats[0]); end
            checks++;
            if (beats[31] !== 8'h7F) begin errors++; $display("FAIL f64_beat32 got %h want 7f", beats[31]); end
            checks++;
            if (beats[63] !== 8'hFF || lasts[63] !== 1'b1) begin
                errors++; $display("FAIL f64_beat64 got %h/%b want ff/1", beats[63], lasts[63]);
            end
            checks++;
            if (lasts[62] !== 1'b0) begin errors++; $display("FAIL f64_last63 got %b want 0", lasts[62]); end
        end
        checks++;
        if (out_valid_b !== 1'b0) begin errors++; $display("FAIL f64_after got out_valid=%b want 0", out_valid_b); end
    endtask

    task automatic test_backpressure();
        logic [7:0] rest [3] = '{8'h20, 8'h30, 8'h40};
        reset_a();
        send_a(8'h40, 1'b0);
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_data_a !== 8'h20 || out_valid_a !== 1'b1 || in_ready_a !== 1'b0 || out_last_a !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got d=%h v=%b r=%b l=%b want d=20 v=1 r=0 l=0",
                         c, out_data_a, out_valid_a, in_ready_a, out_last_a);
            end
        end
        collect_a(1'b0);
        checks++;
        if (beats.size() + 1 != 4) begin errors++; $display("FAIL bp_total got %0d want 4", beats.size() + 1); end
        for (int i = 0; i < 3 && i < beats.size(); i++) begin
            checks++;
            if (beats[i] !== rest[i]) begin errors++; $display("FAIL bp_beat%0d got %h want %h", i + 2, beats[i], rest[i]); end
        end
    endtask

    task automatic test_mode_stability();
        logic [7:0] exp [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
        reset_a();
        send_a(8'h40, 1'b0);
        collect_a(1'b1);
        checks++;
        if (beats.size() != 4) begin errors++; $display("FAIL stable_interp_count got %0d want 4", beats.size()); end
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            checks++;
            if (beats[i] !== exp[i]) begin errors++; $display("FAIL stable_interp_beat%0d got %h want %h", i + 1, beats[i], exp[i]); end
        end
        send_a(8'h90, 1'b1);
        collect_a(1'b1);
        checks++;
        if (beats.size() != 4) begin errors++; $display("FAIL stable_repl_count got %0d want 4", beats.size()); end
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            checks++;
            if (beats[i] !== 8'h90) begin errors++; $display("FAIL stable_repl_beat%0d got %h want 90", i + 1, beats[i]); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_replicate();
        test_interp();
        test_negative_floor();
        test_default_factor();
        test_backpressure();
        test_mode_stability();
        test_reset_mid_block();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
